read_iq_multi: RTL and testbench

READ_IQ_MULTI -- requirements
Module: read_iq_multi

---
 rtl/read_iq_multi.sv | 134 +++++++++++++
 tb/tb_read_iq_multi.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/read_iq_multi.sv
// read_iq_multi: assembles interleaved I/Q samples from a byte FIFO.
// Each sample is 2 bytes (8-bit I, Q) or 4 bytes (16-bit little-endian I, Q).
// Components are sign-extended and left-shifted so both formats share one
// full scale. Finished samples go to paired I/Q output FIFOs, tagged with a
// rotating channel index.
module read_iq_multi #(
   parameter int DATA_SIZE = 32,
   parameter int BYTE_SIZE = 8,
   parameter int BITS      = 10,
   parameter int CHANNELS  = 2
) (
   input  logic                                          clock,
   input  logic                                          reset,
   input  logic                                          mode_16,
   input  logic                                          in_empty,
   output logic                                          in_rd_en,
   input  logic [BYTE_SIZE-1:0]                          in_dout,
   input  logic                                          i_out_full,
   input  logic                                          q_out_full,
   output logic                                          out_wr_en,
   output logic [DATA_SIZE-1:0]                          i_out_din,
   output logic [DATA_SIZE-1:0]                          q_out_din,
   output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] out_chan,
   output logic [15:0]                                   sample_count
);

   localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int COMP_W = 2 * BYTE_SIZE;

   typedef enum logic {S_READ, S_WRITE} state_t;

   state_t                 state, next_state;
   logic [1:0]             byte_idx;
   logic                   mode_lat;
   logic                   cur_mode;
   logic                   last_byte;
   logic                   rd_int;
   logic                   wr_int;
   logic [BYTE_SIZE-1:0]   b0, b1, b2;
   logic signed [DATA_SIZE-1:0] i_next, q_next;

   // Sign-extend a component to the output width, then scale it up.
   function automatic logic signed [DATA_SIZE-1:0] quantise(
      input logic signed [COMP_W-1:0] comp,
      input int                       shift
   );
      logic signed [DATA_SIZE-1:0] wide;
      wide = DATA_SIZE'(comp);
      return wide <<< shift;
   endfunction

   // Byte 0 takes the live format bit; later bytes follow the latched one.
   assign cur_mode  = (byte_idx == 2'd0) ? mode_16 : mode_lat;
   assign last_byte = cur_mode ? (byte_idx == 2'd3) : (byte_idx == 2'd1);

   // Internal strobes stay ungated; only the ports are masked during reset.
   assign in_rd_en  = rd_int & reset;
   assign out_wr_en = wr_int & reset;

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_READ;
      else        state <= next_state;
   end

   // Next-state and handshake strobes.
   always_comb begin
      next_state = state;
      rd_int     = 1'b0;
      wr_int     = 1'b0;
      case (state)
         S_READ: begin
            rd_int = !in_empty;
            if (!in_empty && last_byte) next_state = S_WRITE;
         end
         S_WRITE: begin
            wr_int = !i_out_full && !q_out_full;
            if (!i_out_full && !q_out_full) next_state = S_READ;
         end
         default: next_state = S_READ;
      endcase
   end

   // Quantised values formed from the stored bytes plus the byte at the head.
   always_comb begin
      i_next = '0;
      q_next = '0;
      if (cur_mode) begin
         i_next = quantise({b1, b0}, BITS);
         q_next = quantise({in_dout, b2}, BITS);
      end else begin
         i_next = quantise(COMP_W'($signed(b0)), BITS + BYTE_SIZE);
         q_next = quantise(COMP_W'($signed(in_dout)), BITS + BYTE_SIZE);
      end
   end

   // Sample assembly, output registers, channel rotation and sample counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         byte_idx     <= 2'd0;
         mode_lat     <= 1'b0;
         i_out_din    <= '0;
         q_out_din    <= '0;
         out_chan     <= '0;
         sample_count <= 16'd0;
         b0           <= '0;
         b1           <= '0;
         b2           <= '0;
      end else begin
         if (rd_int) begin
            if (byte_idx == 2'd0) mode_lat <= mode_16;
            case (byte_idx)
               2'd0:    b0 <= in_dout;
               2'd1:    b1 <= in_dout;
               2'd2:    b2 <= in_dout;
               default: ;
            endcase
            if (last_byte) begin
               byte_idx  <= 2'd0;
               i_out_din <= i_next;
               q_out_din <= q_next;
            end else begin
               byte_idx <= byte_idx + 2'd1;
            end
         end
         if (wr_int) begin
            sample_count <= sample_count + 16'd1;
            if (CHANNELS == 1 || out_chan == CH_W'(CHANNELS - 1)) out_chan <= '0;
            else                                                  out_chan <= out_chan + CH_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_read_iq_multi.sv
// Directed bench for read_iq_multi (CHANNELS=3, BITS=10, 32-bit outputs).
module tb_read_iq_multi;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        mode_16 = 1'b1;
   logic        in_empty = 1'b0;
   logic [7:0]  in_dout = 8'h55;
   logic        i_out_full = 1'b0;
   logic        q_out_full = 1'b0;
   logic        in_rd_en;
   logic        out_wr_en;
   logic [31:0] i_out_din;
   logic [31:0] q_out_din;
   logic [1:0]  out_chan;
   logic [15:0] sample_count;

   int n_tests  = 0;
   int n_fail   = 0;
   int n_writes = 0;

   read_iq_multi #(
      .DATA_SIZE(32), .BYTE_SIZE(8), .BITS(10), .CHANNELS(3)
   ) dut (
      .clock(clock), .reset(reset), .mode_16(mode_16), .in_empty(in_empty),
      .in_rd_en(in_rd_en), .in_dout(in_dout), .i_out_full(i_out_full),
      .q_out_full(q_out_full), .out_wr_en(out_wr_en), .i_out_din(i_out_din),
      .q_out_din(q_out_din), .out_chan(out_chan), .sample_count(sample_count)
   );

   always #5 clock = ~clock;

   // Count every write strobe seen mid-cycle.
   always @(negedge clock) if (out_wr_en) n_writes++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one byte after 'gap' empty cycles and wait until it is popped.
   task automatic send_byte(input logic [7:0] b, input int gap);
      bit seen;
      seen = 1'b0;
      repeat (gap) begin
         @(posedge clock);
         #1;
      end
      in_dout  = b;
      in_empty = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         if (in_rd_en) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check_eq("rd_timeout", 32'd0, 32'd1);
      @(posedge clock);
      #1;
      in_empty = 1'b1;
   endtask

   // Wait for a write, check its payload, then check the counter after it.
   task automatic expect_write(input string tag, input logic [31:0] ei, input logic [31:0] eq,
                               input logic [1:0] ech, input logic [15:0] ecnt, output int lat);
      bit seen;
      seen = 1'b0;
      lat  = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         lat++;
         if (out_wr_en) begin
            seen = 1'b1;
            break;
         end
      end
      check_eq({tag, "_wr"}, 32'(seen), 32'd1);
      check_eq({tag, "_i"}, i_out_din, ei);
      check_eq({tag, "_q"}, q_out_din, eq);
      check_eq({tag, "_chan"}, 32'(out_chan), 32'(ech));
      @(posedge clock);
      #1;
      check_eq({tag, "_count"}, 32'(sample_count), 32'(ecnt));
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   logic [7:0]  seq_i  [4] = '{8'h01, 8'h02, 8'h03, 8'h7F};
   logic [7:0]  seq_q  [4] = '{8'hFF, 8'hFE, 8'hFD, 8'h80};
   logic [31:0] seq_ei [4] = '{32'h0004_0000, 32'h0008_0000, 32'h000C_0000, 32'h01FC_0000};
   logic [31:0] seq_eq [4] = '{32'hFFFC_0000, 32'hFFF8_0000, 32'hFFF4_0000, 32'hFE00_0000};
   logic [1:0]  seq_ch [4] = '{2'd0, 2'd1, 2'd2, 2'd0};

   initial begin
      int lat;
      int w0;

      // Reset state, with a byte offered to prove reads are masked.
      @(negedge clock);
      check_eq("rst_rd", 32'(in_rd_en), 32'd0);
      check_eq("rst_wr", 32'(out_wr_en), 32'd0);
      check_eq("rst_i", i_out_din, 32'd0);
      check_eq("rst_q", q_out_din, 32'd0);
      check_eq("rst_chan", 32'(out_chan), 32'd0);
      check_eq("rst_count", 32'(sample_count), 32'd0);
      @(posedge clock);
      #1;
      in_empty = 1'b1;
      reset    = 1'b1;

      // 16-bit sample, one-cycle write latency.
      mode_16 = 1'b1;
      send_byte(8'h34, 0);
      send_byte(8'h12, 0);
      send_byte(8'hCD, 0);
      send_byte(8'hAB, 0);
      expect_write("s16", 32'h0048_D000, 32'hFEAF_3400, 2'd0, 16'd1, lat);
      check_eq("s16_lat", 32'(lat), 32'd1);

      // 8-bit extremes.
      mode_16 = 1'b0;
      send_byte(8'h80, 0);
      send_byte(8'h7F, 0);
      expect_write("s8", 32'hFE00_0000, 32'h01FC_0000, 2'd1, 16'd2, lat);

      // Output back-pressure holds the sample and blocks input reads.
      i_out_full = 1'b1;
      send_byte(8'h01, 0);
      send_byte(8'hFF, 0);
      in_dout  = 8'h77;
      in_empty = 1'b0;
      w0 = n_writes;
      for (int c = 0; c < 5; c++) begin
         q_out_full = (c >= 3);
         @(negedge clock);
         check_eq("full_wr", 32'(out_wr_en), 32'd0);
         check_eq("full_rd", 32'(in_rd_en), 32'd0);
         @(posedge clock);
         #1;
      end
      check_eq("full_i", i_out_din, 32'h0004_0000);
      check_eq("full_chan", 32'(out_chan), 32'd2);
      i_out_full = 1'b0;
      q_out_full = 1'b0;
      in_empty   = 1'b1;
      expect_write("full_rel", 32'h0004_0000, 32'hFFFC_0000, 2'd2, 16'd3, lat);
      repeat (4) @(posedge clock);
      #1;
      check_eq("full_once", 32'(n_writes - w0), 32'd1);

      // Channel rotation over four samples with three channels.
      do_reset();
      mode_16 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         send_byte(seq_i[k], 0);
         send_byte(seq_q[k], 0);
         expect_write("chan_seq", seq_ei[k], seq_eq[k], seq_ch[k], 16'(k + 1), lat);
      end

      // Reset mid-sample clears outputs and discards the partial bytes.
      mode_16 = 1'b1;
      send_byte(8'h34, 0);
      send_byte(8'h12, 0);
      in_dout  = 8'h99;
      in_empty = 1'b0;
      reset    = 1'b0;
      @(negedge clock);
      check_eq("mid_rst_i", i_out_din, 32'd0);
      check_eq("mid_rst_q", q_out_din, 32'd0);
      check_eq("mid_rst_chan", 32'(out_chan), 32'd0);
      check_eq("mid_rst_count", 32'(sample_count), 32'd0);
      check_eq("mid_rst_rd", 32'(in_rd_en), 32'd0);
      @(posedge clock);
      #1;
      in_empty = 1'b1;
      reset    = 1'b1;
      send_byte(8'h34, 0);
      send_byte(8'h12, 0);
      send_byte(8'hCD, 0);
      send_byte(8'hAB, 0);
      expect_write("after_rst", 32'h0048_D000, 32'hFEAF_3400, 2'd0, 16'd1, lat);

      // Input gaps and a mid-sample format change leave the result unchanged.
      do_reset();
      mode_16 = 1'b1;
      send_byte(8'h34, 0);
      mode_16 = 1'b0;
      send_byte(8'h12, 3);
      send_byte(8'hCD, 3);
      send_byte(8'hAB, 3);
      expect_write("gaps", 32'h0048_D000, 32'hFEAF_3400, 2'd0, 16'd1, lat);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
